// File: rtl/lead_scan_sequencer_pkg.sv
// Shared definitions for the lead scan sequencer.
// Contents: FSM state encoding, lead index constants, lead mask type and the
// next-unmasked-lead search used when stepping through a frame.
package lead_scan_sequencer_pkg;

  localparam int unsigned NUM_LEADS = 13;
  localparam int unsigned LEAD_W    = 4;

  // Lead index 0 opens every relay; 1..13 select a lead configuration.
  localparam logic [LEAD_W-1:0] LEAD_OFF = 4'd0;
  localparam logic [LEAD_W-1:0] MAX_LEAD = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BREAK   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ACQUIRE = 3'd3,
    ST_NEXT    = 3'd4
  } scan_state_e;

  // Bit n set means lead n is skipped.
  typedef logic [NUM_LEADS:1] lead_mask_t;

  // Smallest unmasked lead in (cur, last]; LEAD_OFF when none remains.
  function automatic logic [LEAD_W-1:0] next_lead(
    input logic [LEAD_W-1:0] cur,
    input lead_mask_t        mask,
    input logic [LEAD_W-1:0] last
  );
    logic [LEAD_W-1:0] res;
    res = LEAD_OFF;
    for (int i = int'(NUM_LEADS); i >= 1; i--) begin
      if ((LEAD_W'(i) > cur) && (LEAD_W'(i) <= last) && !mask[i]) begin
        res = LEAD_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lead_scan_sequencer_dwell_timer.sv
// Loadable down-counter with zero flag, shared by the BREAK and SETTLE dwells.
// Loading N yields N+1 cycles until zero_c is seen by the controller in its
// state, so the controller loads (dwell - 1). The counter holds at zero.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        load load_value this cycle
//   load_value  new remaining count
//   zero_c      combinational: remaining count is zero
module lead_scan_sequencer_dwell_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero_c
);

  logic [WIDTH-1:0] remaining;

  // Down-count, saturating at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (remaining != '0) begin
      remaining <= remaining - WIDTH'(1);
    end
  end

  assign zero_c = (remaining == '0);

endmodule

// File: rtl/lead_scan_sequencer.sv
// Lead scan sequencer: drives the relay decoder lead index and collects ADC
// samples for each lead of a frame.
// Each lead: BREAK (index 0, relays open) -> SETTLE (index = lead) ->
// ACQUIRE (req/ack per sample) -> NEXT (choose next lead or end frame).
// Optional feature macro: LEAD_MASK_EN adds lead_mask to skip leads.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        pulse, begins a frame from IDLE
//   stop         pulse, aborts any scan back to IDLE
//   continuous   wrap to the first lead at frame end
//   sample_ack   ADC captured the requested sample
//   lead_mask    (LEAD_MASK_EN only) bit n skips lead n
//   count        lead index to relay decoder
//   settled      relays stable on current lead
//   sample_req   sample request, held until acknowledged
//   frame_done   one-cycle pulse at frame end
//   busy         not IDLE
module lead_scan_sequencer
  import lead_scan_sequencer_pkg::*;
#(
  parameter int unsigned LAST_LEAD        = 13,
  parameter int unsigned BREAK_CYCLES     = 64,
  parameter int unsigned SETTLE_CYCLES    = 4096,
  parameter int unsigned SAMPLES_PER_LEAD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic              sample_ack,
`ifdef LEAD_MASK_EN
  input  logic [13:1]       lead_mask,
`endif
  output logic [LEAD_W-1:0] count,
  output logic              settled,
  output logic              sample_req,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned DWELL_MAX = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(DWELL_MAX + 1);
  localparam int unsigned SAMPLE_W  = $clog2(SAMPLES_PER_LEAD + 1);

  localparam logic [TIMER_W-1:0]  BREAK_LOAD  = TIMER_W'(BREAK_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLES_PER_LEAD - 1);
  localparam logic [LEAD_W-1:0]   LAST        = (LAST_LEAD > 13) ? MAX_LEAD : LEAD_W'(LAST_LEAD);

  scan_state_e         state, state_nxt;
  logic [LEAD_W-1:0]   lead, lead_nxt;
  logic [SAMPLE_W-1:0] sample_cnt, sample_cnt_nxt;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_zero;
  logic                frame_end_c;
  logic                handshake_c;
  lead_mask_t          mask_c;
  logic [LEAD_W-1:0]   first_lead_c;
  logic [LEAD_W-1:0]   step_lead_c;

  logic [LEAD_W-1:0]   count_nxt;
  logic                settled_nxt;
  logic                req_nxt;
  logic                done_nxt;
  logic                busy_nxt;

`ifdef LEAD_MASK_EN
  assign mask_c = lead_mask;
`else
  assign mask_c = '0;
`endif

  assign handshake_c  = sample_req & sample_ack;
  assign first_lead_c = next_lead(LEAD_OFF, mask_c, LAST);
  assign step_lead_c  = next_lead(lead, mask_c, LAST);

  lead_scan_sequencer_dwell_timer #(
    .WIDTH(TIMER_W)
  ) u_dwell_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(timer_value),
    .zero_c    (timer_zero)
  );

  // State register with per-lead bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      lead       <= LEAD_OFF;
      sample_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lead       <= lead_nxt;
      sample_cnt <= sample_cnt_nxt;
    end
  end

  // Next-state logic, lead selection and dwell timer control.
  always_comb begin
    state_nxt      = state;
    lead_nxt       = lead;
    sample_cnt_nxt = sample_cnt;
    timer_load     = 1'b0;
    timer_value    = BREAK_LOAD;
    frame_end_c    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (first_lead_c != LEAD_OFF) begin
            state_nxt  = ST_BREAK;
            lead_nxt   = first_lead_c;
            timer_load = 1'b1;
          end else begin
            // Every lead masked: pass through NEXT to end the frame.
            state_nxt = ST_NEXT;
            lead_nxt  = LEAD_OFF;
          end
        end
      end
      ST_BREAK: begin
        if (timer_zero) begin
          state_nxt   = ST_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) begin
          state_nxt      = ST_ACQUIRE;
          sample_cnt_nxt = '0;
        end
      end
      ST_ACQUIRE: begin
        if (handshake_c) begin
          if (sample_cnt == SAMPLE_LAST) begin
            state_nxt = ST_NEXT;
          end else begin
            sample_cnt_nxt = sample_cnt + SAMPLE_W'(1);
          end
        end
      end
      ST_NEXT: begin
        if (step_lead_c != LEAD_OFF) begin
          state_nxt  = ST_BREAK;
          lead_nxt   = step_lead_c;
          timer_load = 1'b1;
        end else begin
          frame_end_c = 1'b1;
          if (continuous && (first_lead_c != LEAD_OFF)) begin
            state_nxt  = ST_BREAK;
            lead_nxt   = first_lead_c;
            timer_load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            lead_nxt  = LEAD_OFF;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        lead_nxt  = LEAD_OFF;
      end
    endcase

    // Abort overrides everything, including a pending ack or frame end.
    if (stop && (state != ST_IDLE)) begin
      state_nxt   = ST_IDLE;
      lead_nxt    = LEAD_OFF;
      timer_load  = 1'b0;
      frame_end_c = 1'b0;
    end
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    count_nxt   = LEAD_OFF;
    settled_nxt = 1'b0;
    req_nxt     = 1'b0;
    done_nxt    = frame_end_c;
    busy_nxt    = (state_nxt != ST_IDLE);

    case (state_nxt)
      ST_SETTLE: begin
        count_nxt = lead_nxt;
      end
      ST_ACQUIRE: begin
        count_nxt   = lead_nxt;
        settled_nxt = 1'b1;
        // Drop for one cycle after each accepted ack, otherwise request.
        req_nxt     = !handshake_c;
      end
      ST_NEXT: begin
        // Relays stay on the finished lead until BREAK opens them.
        count_nxt = count;
      end
      default: begin
        count_nxt = LEAD_OFF;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= LEAD_OFF;
      settled    <= 1'b0;
      sample_req <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      count      <= count_nxt;
      settled    <= settled_nxt;
      sample_req <= req_nxt;
      frame_done <= done_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
